// File: rtl/reg_countdown_pkg.sv
// Purpose : shared state encoding and sizing helper for the reg_countdown timer.
// Latency : n/a (declarations only).
// Ports   : none; imported by tick_prescaler and reg_countdown.
package reg_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Prescaler counter width; one spare bit keeps PRESCALE=1 at a legal 1-bit width.
  function automatic int prescale_width(input int prescale);
    return $clog2(prescale) + 1;
  endfunction

endpackage

// File: rtl/reg_countdown_if.sv
// Purpose : load handshake, run control and status bundle of the countdown timer.
// Latency : n/a (wiring only).
// Ports   : master drives load_valid/load_value/start/stop; slave drives load_ready/count/running/tc_pulse/expired.
interface reg_countdown_if #(
  parameter int WIDTH = 16
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             tc_pulse;
  logic             expired;

  modport master (
    output load_valid, load_value, start, stop,
    input  load_ready, count, running, tc_pulse, expired
  );

  modport slave (
    input  load_valid, load_value, start, stop,
    output load_ready, count, running, tc_pulse, expired
  );

endinterface

// File: rtl/reg_countdown_tick_prescaler.sv
// Purpose : divides clk by PRESCALE while enabled, producing a 1-cycle tick.
// Latency : tick asserts on the PRESCALE-th enabled cycle after a clear.
// Ports   : clk, rst_n, enable (count), clear (synchronous restart, masks tick) -> tick.
module tick_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  import reg_countdown_pkg::*;

  localparam int          PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // A clear on the tick edge swallows the tick, so a stop never lands a decrement.
  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/reg_countdown.sv
// Purpose : loadable down-counting timer with terminal-count pulse, sticky expiry and optional auto-reload.
// Latency : load visible next cycle; first decrement PRESCALE edges after the edge that samples start.
// Ports   : clk, rst_n, bus (slave): load_valid/ready/value, start, stop -> count, running, tc_pulse, expired.
module reg_countdown #(
  parameter int WIDTH       = 16,
  parameter int PRESCALE    = 10,
  parameter int AUTO_RELOAD = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_countdown_if.slave bus
);

  import reg_countdown_pkg::*;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             expired_q;
  logic             load_acc;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;

  assign load_acc = bus.load_valid && (state != ST_RUN);

  // Prescaler is held at zero outside RUN, so entering RUN always starts a fresh period.
  assign pre_en  = (state == ST_RUN);
  assign pre_clr = (state != ST_RUN) || bus.stop;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      // An accepted load takes priority over a start sampled on the same edge.
      if (load_acc) begin
        count_q   <= bus.load_value;
        reload_q  <= bus.load_value;
        expired_q <= 1'b0;
        state     <= ST_LOADED;
      end else begin
        case (state)
          ST_LOADED: begin
            if (bus.start && !bus.stop && (count_q != '0)) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.stop) begin
              state <= ST_LOADED;
            end else if (tick) begin
              if (count_q > ONE) begin
                count_q <= count_q - ONE;
              end else begin
                // count 1 (or a defensive 0) is terminal; never wrap to all-ones.
                tc_q      <= 1'b1;
                expired_q <= 1'b1;
                if (AUTO_RELOAD != 0) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state   <= ST_DONE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.running    = (state == ST_RUN);
  assign bus.load_ready = (state != ST_RUN);
  assign bus.tc_pulse   = tc_q;
  assign bus.expired    = expired_q;

endmodule

// File: tb/tb_reg_countdown.sv
module tb_reg_countdown;

  typedef struct packed {
    logic [15:0] count;
    logic        tc;
    logic        run;
    logic        exp;
  } snap_t;

  logic  clk;
  logic  rst_n;
  int    checks;
  int    errors;
  snap_t sb[$];

  reg_countdown_if #(.WIDTH(16)) i10 ();
  reg_countdown_if #(.WIDTH(16)) i2 ();
  reg_countdown_if #(.WIDTH(16)) i1 ();

  reg_countdown #(.WIDTH(16), .PRESCALE(10), .AUTO_RELOAD(0)) u10 (
    .clk(clk), .rst_n(rst_n), .bus(i10.slave));
  reg_countdown #(.WIDTH(16), .PRESCALE(2), .AUTO_RELOAD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i2.slave));
  reg_countdown #(.WIDTH(16), .PRESCALE(1), .AUTO_RELOAD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t observe(input int inst);
    snap_t s;
    case (inst)
      0:       s = '{i10.count, i10.tc_pulse, i10.running, i10.expired};
      1:       s = '{i2.count, i2.tc_pulse, i2.running, i2.expired};
      default: s = '{i1.count, i1.tc_pulse, i1.running, i1.expired};
    endcase
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (i10.count !== 16'd0 || i10.running !== 1'b0 || i10.tc_pulse !== 1'b0 ||
        i10.expired !== 1'b0 || i10.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_p10 got count=%0d run=%b tc=%b exp=%b rdy=%b want 0 0 0 0 1",
               i10.count, i10.running, i10.tc_pulse, i10.expired, i10.load_ready);
    end
    checks++;
    if (i2.count !== 16'd0 || i2.load_ready !== 1'b1 || i1.count !== 16'd0 || i1.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_p2_p1 got count2=%0d rdy2=%b count1=%0d rdy1=%b want 0 1 0 1",
               i2.count, i2.load_ready, i1.count, i1.load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_oneshot();
    snap_t got, want;
    @(negedge clk);
    i10.load_value = 16'd5;
    i10.load_valid = 1'b1;
    @(negedge clk);
    i10.load_valid = 1'b0;
    checks++;
    if (i10.count !== 16'd5 || i10.running !== 1'b0 || i10.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_load got count=%0d run=%b rdy=%b want 5 0 1", i10.count, i10.running, i10.load_ready);
    end
    i10.start = 1'b1;
    for (int k = 1; k <= 55; k++)
      sb.push_back('{(k < 50) ? 16'(5 - k / 10) : 16'd0, (k == 50), (k < 50), (k >= 50)});
    @(negedge clk);
    i10.start = 1'b0;
    checks++;
    if (i10.running !== 1'b1 || i10.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_enter_run got run=%b rdy=%b want 1 0", i10.running, i10.load_ready);
    end
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      got  = observe(0);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL oneshot_seq cycle %0d got count=%0d tc=%b run=%b exp=%b want count=%0d tc=%b run=%b exp=%b",
                 k, got.count, got.tc, got.run, got.exp, want.count, want.tc, want.run, want.exp);
      end
    end
    i10.start = 1'b1;
    repeat (3) @(negedge clk);
    i10.start = 1'b0;
    checks++;
    if (i10.running !== 1'b0 || i10.count !== 16'd0 || i10.expired !== 1'b1 || i10.tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_start_in_done got run=%b count=%0d exp=%b tc=%b want 0 0 1 0",
               i10.running, i10.count, i10.expired, i10.tc_pulse);
    end
  endtask

  task automatic test_autoreload();
    snap_t got, want;
    @(negedge clk);
    i2.load_value = 16'd3;
    i2.load_valid = 1'b1;
    @(negedge clk);
    i2.load_valid = 1'b0;
    i2.start      = 1'b1;
    for (int k = 1; k <= 20; k++)
      sb.push_back('{16'(3 - (k / 2) % 3), (k % 6 == 0), 1'b1, (k >= 6)});
    @(negedge clk);
    i2.start = 1'b0;
    // A load request held across the run must be refused and leave the sequence alone.
    i2.load_value = 16'hFFFF;
    i2.load_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      got  = observe(1);
      want = sb.pop_front();
      checks++;
      if (got !== want || i2.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL autoreload_seq cycle %0d got count=%0d tc=%b run=%b exp=%b rdy=%b want count=%0d tc=%b run=%b exp=%b rdy=0",
                 k, got.count, got.tc, got.run, got.exp, i2.load_ready, want.count, want.tc, want.run, want.exp);
      end
    end
    i2.load_valid = 1'b0;
    i2.stop       = 1'b1;
    @(negedge clk);
    i2.stop = 1'b0;
    checks++;
    if (i2.running !== 1'b0 || i2.count !== 16'd2 || i2.expired !== 1'b1) begin
      errors++;
      $display("FAIL autoreload_stop got run=%b count=%0d exp=%b want 0 2 1", i2.running, i2.count, i2.expired);
    end
    i2.start = 1'b1;
    i2.stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (i2.running !== 1'b0 || i2.count !== 16'd2) begin
        errors++;
        $display("FAIL start_stop_in_loaded cycle %0d got run=%b count=%0d want 0 2", k, i2.running, i2.count);
      end
    end
    i2.start      = 1'b0;
    i2.stop       = 1'b0;
    i2.load_value = 16'd3;
    i2.load_valid = 1'b1;
    @(negedge clk);
    i2.load_valid = 1'b0;
    checks++;
    if (i2.expired !== 1'b0 || i2.count !== 16'd3) begin
      errors++;
      $display("FAIL autoreload_load_clears got exp=%b count=%0d want 0 3", i2.expired, i2.count);
    end
  endtask

  task automatic test_stop_restart();
    snap_t got, want;
    @(negedge clk);
    i10.load_value = 16'd5;
    i10.load_valid = 1'b1;
    @(negedge clk);
    i10.load_valid = 1'b0;
    i10.start      = 1'b1;
    for (int k = 1; k <= 24; k++) sb.push_back('{16'(5 - k / 10), 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    i10.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      got  = observe(0);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stop_first_run cycle %0d got count=%0d run=%b want count=%0d run=%b",
                 k, got.count, got.run, want.count, want.run);
      end
      if (k == 24) i10.stop = 1'b1;
    end
    @(negedge clk);
    i10.stop = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (i10.running !== 1'b0 || i10.count !== 16'd3) begin
      errors++;
      $display("FAIL stop_hold got run=%b count=%0d want 0 3", i10.running, i10.count);
    end
    // Restart, then stop exactly on the tick edge: that tick must be lost.
    i10.start = 1'b1;
    for (int k = 1; k <= 9; k++) sb.push_back('{16'd3, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    i10.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      got  = observe(0);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL restart_prescaler cycle %0d got count=%0d run=%b want count=%0d run=%b",
                 k, got.count, got.run, want.count, want.run);
      end
    end
    i10.stop = 1'b1;
    @(negedge clk);
    i10.stop = 1'b0;
    checks++;
    if (i10.running !== 1'b0 || i10.count !== 16'd3) begin
      errors++;
      $display("FAIL stop_on_tick got run=%b count=%0d want 0 3", i10.running, i10.count);
    end
    i10.start = 1'b1;
    for (int k = 1; k <= 10; k++) sb.push_back('{(k < 10) ? 16'd3 : 16'd2, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    i10.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      got  = observe(0);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL second_restart cycle %0d got count=%0d run=%b want count=%0d run=%b",
                 k, got.count, got.run, want.count, want.run);
      end
    end
    i10.stop = 1'b1;
    @(negedge clk);
    i10.stop = 1'b0;
  endtask

  task automatic test_prescale1();
    snap_t got, want;
    @(negedge clk);
    i1.load_value = 16'h0001;
    i1.load_valid = 1'b1;
    @(negedge clk);
    i1.load_valid = 1'b0;
    i1.start      = 1'b1;
    sb.push_back('{16'd1, 1'b0, 1'b1, 1'b0});
    sb.push_back('{16'd0, 1'b1, 1'b0, 1'b1});
    sb.push_back('{16'd0, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i1.start = 1'b0;
      got  = observe(2);
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL prescale1_seq cycle %0d got count=%0d tc=%b run=%b exp=%b want count=%0d tc=%b run=%b exp=%b",
                 k, got.count, got.tc, got.run, got.exp, want.count, want.tc, want.run, want.exp);
      end
    end
    i1.load_value = 16'd0;
    i1.load_valid = 1'b1;
    @(negedge clk);
    i1.load_valid = 1'b0;
    i1.start      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (i1.running !== 1'b0 || i1.tc_pulse !== 1'b0 || i1.count !== 16'd0 ||
          i1.load_ready !== 1'b1 || i1.expired !== 1'b0) begin
        errors++;
        $display("FAIL load_zero_start cycle %0d got run=%b tc=%b count=%0d rdy=%b exp=%b want 0 0 0 1 0",
                 k, i1.running, i1.tc_pulse, i1.count, i1.load_ready, i1.expired);
      end
    end
    i1.start = 1'b0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    i10.load_value = 16'd5;
    i10.load_valid = 1'b1;
    @(negedge clk);
    i10.load_valid = 1'b0;
    i10.start      = 1'b1;
    @(negedge clk);
    i10.start = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (i10.count !== 16'd4 || i10.running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_before_reset got count=%0d run=%b want 4 1", i10.count, i10.running);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (i10.count !== 16'd0 || i10.running !== 1'b0 || i10.load_ready !== 1'b1 || i2.count !== 16'd0) begin
      errors++;
      $display("FAIL midrun_async_reset got count=%0d run=%b rdy=%b count2=%0d want 0 0 1 0",
               i10.count, i10.running, i10.load_ready, i2.count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i10.load_valid = 1'b0; i10.load_value = '0; i10.start = 1'b0; i10.stop = 1'b0;
    i2.load_valid  = 1'b0; i2.load_value  = '0; i2.start  = 1'b0; i2.stop  = 1'b0;
    i1.load_valid  = 1'b0; i1.load_value  = '0; i1.start  = 1'b0; i1.stop  = 1'b0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_stop_restart();
    test_prescale1();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
